apb_master: RTL
===============

Name: apb_master

Overview:
- APB requester: the initiating end of the APB link whose completer is the existing UART APB bridge.
- Accepts single read/write commands on a valid/ready command port.
- Sequences each command through the APB SETUP and ACCESS phases, waits for pready, and returns the result on a valid/ready response port.
- Sits between the test/control logic and the UART APB bridge; one outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 8, width of paddr / cmd_addr (upper nibble = RAM slot select, lower nibble = command code at the completer)
- DATA_WIDTH, 8, width of pwdata / prdata / cmd_wdata / rsp_rdata
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit before abort (used only with APB_TIMEOUT_EN); must be >= 2

Ports:
- pclk  input  1  clock, all logic on rising edge
- prstn  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when high with rsp_valid
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
- rsp_slverr  output  1  error: completer pslverr, or timeout abort
- rsp_timeout  output  1  response produced by timeout abort
- paddr  output  ADDR_WIDTH  APB address
- pselx  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- pwdata  output  DATA_WIDTH  APB write data
- pready  input  1  APB completer ready
- prdata  input  DATA_WIDTH  APB read data
- pslverr  input  1  APB completer error

Behaviour:
- Reset: sync active-low; sampled at posedge pclk.
  - State goes to IDLE.
  - All outputs registered and cleared to 0 (paddr, pwdata, pwrite, pselx, penable, rsp_*); cmd_ready = 1 from the first cycle after reset.
- Reset mid-transfer (SETUP/ACCESS/RESP): the transfer is dropped. pselx/penable are 0 after that edge, no response is issued, and the state is IDLE.
- States: IDLE, SETUP, ACCESS, RESP (2-bit encoding).
- IDLE:
  - cmd_ready = 1 (decoded from state), pselx = penable = 0.
  - On cmd_valid & cmd_ready: register cmd_addr→paddr, cmd_write→pwrite, cmd_wdata→pwdata; go to SETUP.
- SETUP: pselx = 1, penable = 0 for exactly one cycle, then ACCESS.
- ACCESS:
  - pselx = 1, penable = 1.
  - paddr/pwrite/pwdata are stable from SETUP until the cycle after completion.
  - Completion: on a cycle with pready = 1:
    - rsp_rdata <= prdata for reads, 0 for writes.
    - rsp_slverr <= pslverr; rsp_timeout <= 0.
    - pselx/penable <= 0; go to RESP.
  - pready = 0: stay in ACCESS (wait state); no limit unless APB_TIMEOUT_EN.
- RESP:
  - rsp_valid = 1; rsp_rdata/rsp_slverr/rsp_timeout held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - cmd_ready = 0 throughout.
- Latency, zero-wait completer: accept at edge T, SETUP at T+1, ACCESS at T+2, rsp_valid high from T+3. Each wait state adds 1 cycle. Next command can be accepted one cycle after the response handshake.
- pready/pslverr/prdata are ignored outside ACCESS.
- paddr/pwrite/pwdata keep their last values in IDLE and RESP.
- pselx never deasserts between SETUP and ACCESS.
- penable is never high without pselx.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When it reaches TIMEOUT_CYCLES-1 while pready is still 0, the transfer aborts:
    - pselx/penable <= 0, go to RESP.
    - rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
  - pready = 1 on the limit cycle takes priority: normal completion.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout tied to 0.

Test Plan:
- Write, zero-wait: cmd write addr 0x30, data 0xA5, pready = 1.
  - SETUP then ACCESS with paddr = 0x30, pwrite = 1, pwdata = 0xA5.
  - rsp_valid at T+3, rsp_slverr = 0, rsp_rdata = 0.
- Read, 3 wait states: cmd read addr 0x24; pready low 3 ACCESS cycles, then high with prdata = 0x5C.
  - penable high 4 cycles, paddr stable.
  - rsp_rdata = 0x5C, rsp_valid at T+6.
- Error: pslverr = 1 with pready on a read, prdata = 0xFF.
  - rsp_slverr = 1, rsp_rdata = 0xFF, rsp_timeout = 0.
- Response backpressure: rsp_ready low 5 cycles.
  - rsp_* stable, cmd_ready = 0, a new cmd_valid is not accepted.
  - After the handshake, cmd_ready = 1 next cycle; a second command is accepted.
- Reset mid-ACCESS: prstn low 1 cycle during a wait state.
  - Next cycle pselx = penable = rsp_valid = 0, cmd_ready = 1, no response emitted.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, pready held 0.
  - Abort after 16 ACCESS cycles: rsp_slverr = 1, rsp_timeout = 1, pselx = 0.
  - Without the macro, still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: APB requester.
//
// Takes one read or write command at a time on a valid/ready command port.
// It runs the command through the APB SETUP and ACCESS phases, waits for
// pready, and returns the result on a valid/ready response port.
//
// Ports:
//   pclk, prstn          clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  command address and write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes and for timeout aborts)
//   rsp_slverr           completer pslverr, or timeout abort
//   rsp_timeout          response came from a timeout abort
//   paddr, pselx, penable, pwrite, pwdata   APB requester outputs (registered)
//   pready, prdata, pslverr                 APB completer inputs (sampled only in ACCESS)
//
// Optional build macro APB_TIMEOUT_EN: when defined, an ACCESS phase that has
// waited TIMEOUT_CYCLES cycles without pready is aborted with
// rsp_slverr = rsp_timeout = 1. When undefined, ACCESS waits indefinitely and
// rsp_timeout is tied to 0.
module apb_master #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  pwrite_d;
  logic                  pselx_d;
  logic                  penable_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  rsp_slverr_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic             rsp_timeout_d;
`else
  // TIMEOUT_CYCLES only takes effect in the timeout build.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_unused
  end
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);

  always_comb begin
    state_d      = state;
    paddr_d      = paddr;
    pwdata_d     = pwdata;
    pwrite_d     = pwrite;
    pselx_d      = pselx;
    penable_d    = penable;
    rsp_valid_d  = rsp_valid;
    rsp_rdata_d  = rsp_rdata;
    rsp_slverr_d = rsp_slverr;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt;
    rsp_timeout_d = rsp_timeout;
`endif
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = cmd_write;
          pselx_d   = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d  = pwrite ? '0 : prdata;
          rsp_slverr_d = pslverr;
          rsp_valid_d  = 1'b1;
          pselx_d      = 1'b0;
          penable_d    = 1'b0;
          state_d      = RESP;
`ifdef APB_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (wait_cnt == CNT_LIMIT) begin
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          pselx_d       = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!prstn) begin
      state      <= IDLE;
      paddr      <= '0;
      pwdata     <= '0;
      pwrite     <= 1'b0;
      pselx      <= 1'b0;
      penable    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      state      <= state_d;
      paddr      <= paddr_d;
      pwdata     <= pwdata_d;
      pwrite     <= pwrite_d;
      pselx      <= pselx_d;
      penable    <= penable_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_slverr <= rsp_slverr_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      wait_cnt    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      wait_cnt    <= wait_cnt_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end
`endif

endmodule
